// File: rtl/tile_map_engine.sv
// Writable per-level tile map with 1-cycle pixel lookup, coin/brick/gate edits and a coin counter.
// Optional build macro TILE_MAP_CRUMBLE_EN: BREAK frees a brick after BREAK_FRAMES frames instead of at once.
module tile_map_engine #(
    parameter int NUM_ROWS     = 7,
    parameter int NUM_COLS     = 10,
    parameter int TILE_SHIFT   = 6,
    parameter int NUM_LEVELS   = 4,
    parameter int TYPE_W       = 3,
    parameter int OFFSET_X     = 7,
    parameter int OFFSET_Y     = 50,
    parameter int BREAK_FRAMES = 8
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [$clog2(NUM_LEVELS)-1:0]                   level,
    input  logic                                            level_load,
    output logic [$clog2(NUM_LEVELS*NUM_ROWS*NUM_COLS)-1:0] rom_addr,
    input  logic [TYPE_W+7:0]                               rom_data,
    output logic                                            busy,
    input  logic [10:0]                                     pixelX,
    input  logic [10:0]                                     pixelY,
    input  logic                                            startOfFrame,
    output logic [TYPE_W-1:0]                               tile_type,
    output logic [7:0]                                      teleport_cordinates,
    output logic [10:0]                                     tileTopLeftX,
    output logic [10:0]                                     tileTopLeftY,
    output logic [10:0]                                     offsetX,
    output logic [10:0]                                     offsetY,
    input  logic                                            upd_valid,
    output logic                                            upd_ready,
    input  logic                                            upd_kind,
    input  logic [3:0]                                      upd_col,
    input  logic [3:0]                                      upd_row,
    input  logic                                            gate,
    input  logic [3:0]                                      gate_col,
    input  logic [3:0]                                      gate_row,
    output logic [7:0]                                      coins_left,
    output logic                                            level_clear
);
    localparam int CELLS = NUM_ROWS * NUM_COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int AW    = $clog2(NUM_LEVELS * CELLS);
    localparam int CW    = $clog2(CELLS + 1);
    localparam logic [TYPE_W-1:0] T_FREE = '0;
    localparam logic [TYPE_W-1:0] T_GATE = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_COIN = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] T_BRAK = TYPE_W'(6);
    localparam logic [3:0]  COLS4  = 4'(NUM_COLS);
    localparam logic [3:0]  ROWS4  = 4'(NUM_ROWS);
    localparam logic [10:0] COLS11 = 11'(NUM_COLS);
    localparam logic [10:0] ROWS11 = 11'(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state;

    logic [TYPE_W-1:0] map_type [CELLS];
    logic [7:0]        map_tp   [CELLS];
    logic [CW-1:0]     load_cnt;
    logic [IDX_W-1:0]  load_idx, px_idx, upd_idx, gate_idx, crumble_idx;
    logic [10:0]       px_col, px_row, tl_x, tl_y;
    logic [TYPE_W+7:0] saved;
    logic gate_q, saved_flag, px_hit, upd_in, gate_in, run, load_start;
    logic upd_fire, collect, brk, upd_free, gate_rise, gate_fall, gate_wr;
    logic crumble_wr, upd_lose, upd_wr, coin_dec;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [10:0] c, input logic [10:0] r);
        return IDX_W'(int'(r) * NUM_COLS + int'(c));
    endfunction

    assign px_col   = pixelX >> TILE_SHIFT;
    assign px_row   = pixelY >> TILE_SHIFT;
    assign tl_x     = px_col << TILE_SHIFT;
    assign tl_y     = px_row << TILE_SHIFT;
    assign px_hit   = (px_col < COLS11) && (px_row < ROWS11);
    assign px_idx   = cell_idx(px_col, px_row);
    assign upd_in   = (upd_col < COLS4) && (upd_row < ROWS4);
    assign gate_in  = (gate_col < COLS4) && (gate_row < ROWS4);
    assign upd_idx  = cell_idx({7'd0, upd_col}, {7'd0, upd_row});
    assign gate_idx = cell_idx({7'd0, gate_col}, {7'd0, gate_row});
    assign load_idx = IDX_W'(load_cnt - 1'b1);

    // A reload request pre-empts every edit in the same cycle.
    assign run        = (state == RUN) && !level_load;
    assign load_start = level_load && (state != LOAD);
    assign upd_fire   = run && upd_valid && upd_in;
    assign collect    = upd_fire && !upd_kind && (map_type[upd_idx] == T_COIN);
    assign brk        = upd_fire && upd_kind && (map_type[upd_idx] == T_BRAK);
    assign gate_rise  = run && gate && !gate_q && gate_in;
    assign gate_fall  = run && !gate && gate_q && gate_in && saved_flag;
    assign gate_wr    = gate_rise || gate_fall;
    assign upd_lose   = (gate_wr && (gate_idx == upd_idx)) || (crumble_wr && (crumble_idx == upd_idx));
    assign upd_wr     = upd_free && !upd_lose;
    assign coin_dec   = collect && !upd_lose;

    assign upd_ready   = (state == RUN);
    assign level_clear = (state == RUN) && (coins_left == 8'd0);

`ifdef TILE_MAP_CRUMBLE_EN
    localparam int FW = $clog2(BREAK_FRAMES) + 1;
    logic          crumble_busy;
    logic [FW-1:0] frame_cnt;

    assign upd_free   = collect;
    assign crumble_wr = run && crumble_busy && startOfFrame && (frame_cnt == FW'(BREAK_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (reset || load_start) begin
            crumble_busy <= 1'b0;
            crumble_idx  <= '0;
            frame_cnt    <= '0;
        end else if (crumble_wr) begin
            crumble_busy <= 1'b0;
        end else if (run && crumble_busy && startOfFrame) begin
            frame_cnt <= frame_cnt + 1'b1;
        end else if (brk && !crumble_busy) begin
            crumble_busy <= 1'b1;
            crumble_idx  <= upd_idx;
            frame_cnt    <= '0;
        end
    end
`else
    // Frame pulses only drive the crumble delay, which this build omits.
    logic unused_frames;
    assign unused_frames = startOfFrame | (BREAK_FRAMES == 0);
    assign upd_free      = collect || brk;
    assign crumble_wr    = 1'b0;
    assign crumble_idx   = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            load_cnt   <= '0;
            rom_addr   <= '0;
            busy       <= 1'b0;
            coins_left <= '0;
            gate_q     <= 1'b0;
            saved_flag <= 1'b0;
            saved      <= '0;
            for (int i = 0; i < CELLS; i++) begin
                map_type[i] <= T_FREE;
                map_tp[i]   <= '0;
            end
        end else begin
            gate_q <= gate;
            case (state)
                IDLE, RUN: if (level_load) begin
                    state      <= LOAD;
                    load_cnt   <= '0;
                    busy       <= 1'b1;
                    coins_left <= '0;
                    saved_flag <= 1'b0;
                    rom_addr   <= AW'(level) * AW'(CELLS);
                end
                LOAD: begin
                    // ROM data trails the address by one cycle, so cell n is written at count n+1.
                    load_cnt <= load_cnt + 1'b1;
                    if (load_cnt < CW'(CELLS - 1)) rom_addr <= rom_addr + 1'b1;
                    if (load_cnt != '0) begin
                        map_type[load_idx] <= rom_data[TYPE_W+7:8];
                        map_tp[load_idx]   <= rom_data[7:0];
                        if (rom_data[TYPE_W+7:8] == T_COIN) coins_left <= coins_left + 1'b1;
                    end
                    if (load_cnt == CW'(CELLS)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (upd_wr) begin
                map_type[upd_idx] <= T_FREE;
                map_tp[upd_idx]   <= '0;
            end
            if (crumble_wr && !(gate_wr && (gate_idx == crumble_idx))) begin
                map_type[crumble_idx] <= T_FREE;
                map_tp[crumble_idx]   <= '0;
            end
            if (gate_rise) begin
                saved              <= {map_type[gate_idx], map_tp[gate_idx]};
                saved_flag         <= 1'b1;
                map_type[gate_idx] <= T_GATE;
                map_tp[gate_idx]   <= '0;
            end else if (gate_fall) begin
                map_type[gate_idx] <= saved[TYPE_W+7:8];
                map_tp[gate_idx]   <= saved[7:0];
            end
            if (coin_dec && (coins_left != 8'd0)) coins_left <= coins_left - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tile_type           <= '0;
            teleport_cordinates <= '0;
            tileTopLeftX        <= '0;
            tileTopLeftY        <= '0;
            offsetX             <= '0;
            offsetY             <= '0;
        end else begin
            tileTopLeftX <= tl_x;
            tileTopLeftY <= tl_y;
            offsetX      <= pixelX - tl_x - 11'(OFFSET_X);
            offsetY      <= pixelY - tl_y - 11'(OFFSET_Y);
            if ((state == RUN) && px_hit) begin
                tile_type           <= map_type[px_idx];
                teleport_cordinates <= map_tp[px_idx];
            end else begin
                tile_type           <= T_FREE;
                teleport_cordinates <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tile_map_engine.sv
// Randomized self-checking bench for tile_map_engine against a cell-grid model and a ROM model.
module tb_tile_map_engine;
    localparam int R = 7, C = 10, CELLS = 70;
    localparam int FREE = 0, REGU = 1, GATE = 2, COIN = 3, PORT = 4, SPIK = 5, BRAK = 6;

    logic        clk = 0, reset = 1, level_load = 0, busy, startOfFrame = 0;
    logic [1:0]  level = 0;
    logic [8:0]  rom_addr;
    logic [10:0] rom_data = 0;
    logic [10:0] pixelX = 0, pixelY = 0, tileTopLeftX, tileTopLeftY, offsetX, offsetY;
    logic [2:0]  tile_type;
    logic [7:0]  teleport_cordinates, coins_left;
    logic        upd_valid = 0, upd_ready, upd_kind = 0, gate = 0, level_clear;
    logic [3:0]  upd_col = 0, upd_row = 0, gate_col = 9, gate_row = 1;

    tile_map_engine dut (
        .clk(clk), .reset(reset), .level(level), .level_load(level_load),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .tile_type(tile_type), .teleport_cordinates(teleport_cordinates),
        .tileTopLeftX(tileTopLeftX), .tileTopLeftY(tileTopLeftY),
        .offsetX(offsetX), .offsetY(offsetY),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_kind(upd_kind),
        .upd_col(upd_col), .upd_row(upd_row),
        .gate(gate), .gate_col(gate_col), .gate_row(gate_row),
        .coins_left(coins_left), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    logic [10:0] rom [512];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int ref_t [R][C];
    int ref_p [R][C];
    int ref_coins;
    int checks = 0, errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_model(input int lv);
        ref_coins = 0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                ref_t[r][c] = int'(rom[lv*CELLS + r*C + c][10:8]);
                ref_p[r][c] = int'(rom[lv*CELLS + r*C + c][7:0]);
                if (ref_t[r][c] == COIN) ref_coins++;
            end
    endtask

    task automatic probe(input int c, input int r, output logic [2:0] t, output logic [7:0] p);
        pixelX = 11'(c*64 + int'($urandom_range(0, 63)));
        pixelY = 11'(r*64 + int'($urandom_range(0, 63)));
        step();
        t = tile_type;
        p = teleport_cordinates;
    endtask

    task automatic edit(input logic kind, input int c, input int r);
        upd_valid = 1; upd_kind = kind; upd_col = 4'(c); upd_row = 4'(r);
        step();
        upd_valid = 0;
    endtask

    task automatic pulse();
        startOfFrame = 1;
        step();
        startOfFrame = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        step(); step();
        checks++;
        if ({busy, upd_ready, level_clear} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got busy/ready/clear=%b%b%b want 000", busy, upd_ready, level_clear);
        end
        checks++;
        if (coins_left !== 0 || rom_addr !== 0) begin
            errors++; $display("FAIL reset_counts got coins=%0d rom_addr=%0d want 0 0", coins_left, rom_addr);
        end
        checks++;
        if ({tile_type, teleport_cordinates, tileTopLeftX, tileTopLeftY, offsetX, offsetY} !== '0) begin
            errors++; $display("FAIL reset_lookup got type=%0d tp=%0d offX=%0d offY=%0d want all 0", tile_type, teleport_cordinates, offsetX, offsetY);
        end
        reset = 0;
        step();
    endtask

    task automatic test_load(input int lv);
        int n;
        load_model(lv);
        pixelX = 70; pixelY = 130;
        level = 2'(lv); level_load = 1;
        step();
        level_load = 0;
        checks++;
        if (rom_addr !== 9'(lv*CELLS)) begin
            errors++; $display("FAIL load_first_addr got %0d want %0d", rom_addr, lv*CELLS);
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 35) begin
                checks++;
                if (tile_type !== 3'(FREE) || teleport_cordinates !== 0) begin
                    errors++; $display("FAIL lookup_in_load got type=%0d tp=%0d want 0 0", tile_type, teleport_cordinates);
                end
            end
            if (n == 50) begin
                checks++;
                if (rom_addr !== 9'(lv*CELLS + 49)) begin
                    errors++; $display("FAIL load_addr_step got %0d want %0d", rom_addr, lv*CELLS + 49);
                end
            end
            step();
        end
        checks++;
        if (n != 71) begin
            errors++; $display("FAIL load_busy_cycles got %0d want 71", n);
        end
        checks++;
        if (coins_left !== 8'(ref_coins) || upd_ready !== 1'b1) begin
            errors++; $display("FAIL load_coins got coins=%0d ready=%b want %0d 1", coins_left, upd_ready, ref_coins);
        end
    endtask

    task automatic test_lookup();
        int x, y, cc, rr, et, ep, tx, ty;
        pixelX = 70; pixelY = 130;
        step();
        checks++;
        if (tile_type !== 3'(ref_t[2][1]) || teleport_cordinates !== 8'(ref_p[2][1])) begin
            errors++; $display("FAIL lookup_70_130 got type=%0d tp=%0d want %0d %0d", tile_type, teleport_cordinates, ref_t[2][1], ref_p[2][1]);
        end
        checks++;
        if (tileTopLeftX !== 64 || tileTopLeftY !== 128 || offsetX !== 2047 || offsetY !== 2000) begin
            errors++; $display("FAIL geom_70_130 got tl=(%0d,%0d) off=(%0d,%0d) want (64,128) (2047,2000)", tileTopLeftX, tileTopLeftY, offsetX, offsetY);
        end
        for (int i = 0; i < 16; i++) begin
            x = int'($urandom_range(0, 2047));
            y = (i < 8) ? int'($urandom_range(0, 447)) : int'($urandom_range(0, 2047));
            cc = x / 64; rr = y / 64;
            et = (cc < C && rr < R) ? ref_t[rr][cc] : FREE;
            ep = (cc < C && rr < R) ? ref_p[rr][cc] : 0;
            tx = cc * 64; ty = rr * 64;
            pixelX = 11'(x); pixelY = 11'(y);
            step();
            checks++;
            if (tile_type !== 3'(et) || teleport_cordinates !== 8'(ep)) begin
                errors++; $display("FAIL lookup_rand (%0d,%0d) got type=%0d tp=%0d want %0d %0d", x, y, tile_type, teleport_cordinates, et, ep);
            end
            checks++;
            if (tileTopLeftX !== 11'(tx) || tileTopLeftY !== 11'(ty) ||
                offsetX !== 11'((x - tx - 7) & 2047) || offsetY !== 11'((y - ty - 50) & 2047)) begin
                errors++; $display("FAIL geom_rand (%0d,%0d) got tl=(%0d,%0d) off=(%0d,%0d)", x, y, tileTopLeftX, tileTopLeftY, offsetX, offsetY);
            end
        end
    endtask

    task automatic test_out_of_grid();
        pixelX = 700; pixelY = 300;
        step();
        checks++;
        if (tile_type !== 3'(FREE) || teleport_cordinates !== 0) begin
            errors++; $display("FAIL oog_col10 got type=%0d tp=%0d want 0 0", tile_type, teleport_cordinates);
        end
        checks++;
        if (tileTopLeftX !== 640 || tileTopLeftY !== 256 || offsetX !== 53 || offsetY !== 2042) begin
            errors++; $display("FAIL oog_geom got tl=(%0d,%0d) off=(%0d,%0d) want (640,256) (53,2042)", tileTopLeftX, tileTopLeftY, offsetX, offsetY);
        end
    endtask

    task automatic test_collect();
        logic [2:0] t; logic [7:0] p;
        edit(0, 3, 3);
        ref_t[3][3] = FREE; ref_coins--;
        probe(3, 3, t, p);
        checks++;
        if (t !== 3'(FREE) || coins_left !== 8'(ref_coins) || level_clear !== 0) begin
            errors++; $display("FAIL collect_first got type=%0d coins=%0d clear=%b want 0 %0d 0", t, coins_left, level_clear, ref_coins);
        end
        edit(0, 3, 3);
        edit(0, 9, 1);
        step();
        checks++;
        if (coins_left !== 8'(ref_coins)) begin
            errors++; $display("FAIL collect_repeat got coins=%0d want %0d", coins_left, ref_coins);
        end
        // (15,3) is outside the grid but aliases linear index of the coin at (5,4)
        edit(0, 15, 3);
        probe(5, 4, t, p);
        checks++;
        if (t !== 3'(ref_t[4][5]) || coins_left !== 8'(ref_coins)) begin
            errors++; $display("FAIL collect_oog got type=%0d coins=%0d want %0d %0d", t, coins_left, ref_t[4][5], ref_coins);
        end
    endtask

    task automatic test_gate();
        logic [2:0] t; logic [7:0] p;
        int saved_t;
        gate_col = 9; gate_row = 1;
        saved_t = ref_t[1][9];
        gate = 1; step();
        probe(9, 1, t, p);
        checks++;
        if (t !== 3'(GATE)) begin
            errors++; $display("FAIL gate_rise got type=%0d want %0d", t, GATE);
        end
        gate = 0; step();
        probe(9, 1, t, p);
        checks++;
        if (t !== 3'(saved_t)) begin
            errors++; $display("FAIL gate_fall got type=%0d want %0d", t, saved_t);
        end
        gate_col = 5; gate_row = 4;
        saved_t = ref_t[4][5];
        gate = 1;
        edit(0, 5, 4);
        probe(5, 4, t, p);
        checks++;
        if (t !== 3'(GATE) || coins_left !== 8'(ref_coins)) begin
            errors++; $display("FAIL gate_vs_collect got type=%0d coins=%0d want %0d %0d", t, coins_left, GATE, ref_coins);
        end
        gate = 0; step();
        probe(5, 4, t, p);
        checks++;
        if (t !== 3'(saved_t)) begin
            errors++; $display("FAIL gate_restore_coin got type=%0d want %0d", t, saved_t);
        end
    endtask

    task automatic test_break();
        logic [2:0] t; logic [7:0] p;
`ifdef TILE_MAP_CRUMBLE_EN
        edit(1, 0, 2);
        for (int k = 1; k <= 7; k++) begin
            pulse();
            if (k == 3) edit(1, 4, 5);
            probe(0, 2, t, p);
            checks++;
            if (t !== 3'(BRAK)) begin
                errors++; $display("FAIL crumble_pending pulse %0d got type=%0d want %0d", k, t, BRAK);
            end
        end
        pulse();
        ref_t[2][0] = FREE;
        probe(0, 2, t, p);
        checks++;
        if (t !== 3'(FREE)) begin
            errors++; $display("FAIL crumble_done got type=%0d want 0", t);
        end
        probe(4, 5, t, p);
        checks++;
        if (t !== 3'(BRAK)) begin
            errors++; $display("FAIL crumble_busy_drop got type=%0d want %0d", t, BRAK);
        end
`else
        edit(1, 0, 2);
        ref_t[2][0] = FREE;
        probe(0, 2, t, p);
        checks++;
        if (t !== 3'(FREE)) begin
            errors++; $display("FAIL break_now got type=%0d want 0", t);
        end
        edit(1, 4, 5);
        ref_t[5][4] = FREE;
        probe(4, 5, t, p);
        checks++;
        if (t !== 3'(FREE)) begin
            errors++; $display("FAIL break_second got type=%0d want 0", t);
        end
`endif
        edit(1, 9, 1);
        probe(9, 1, t, p);
        checks++;
        if (t !== 3'(ref_t[1][9])) begin
            errors++; $display("FAIL break_non_brick got type=%0d want %0d", t, ref_t[1][9]);
        end
    endtask

    task automatic test_clear();
        edit(0, 5, 4);
        edit(0, 7, 0);
        step();
        checks++;
        if (coins_left !== 8'(ref_coins - 2) || level_clear !== 0) begin
            errors++; $display("FAIL clear_partial got coins=%0d clear=%b want %0d 0", coins_left, level_clear, ref_coins - 2);
        end
        edit(0, 2, 6);
        ref_coins = 0;
        step();
        checks++;
        if (coins_left !== 0 || level_clear !== 1) begin
            errors++; $display("FAIL level_clear got coins=%0d clear=%b want 0 1", coins_left, level_clear);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [2:0] t; logic [7:0] p;
        int cc, rr;
        level = 1; level_load = 1;
        step();
        level_load = 0;
        repeat (29) step();
        reset = 1;
        step();
        checks++;
        if ({busy, upd_ready, level_clear} !== 3'b000 || coins_left !== 0 || rom_addr !== 0 || tile_type !== 0) begin
            errors++; $display("FAIL reset_mid_load got busy=%b ready=%b coins=%0d addr=%0d", busy, upd_ready, coins_left, rom_addr);
        end
        reset = 0;
        step();
        probe(1, 2, t, p);
        checks++;
        if (t !== 3'(FREE) || p !== 0) begin
            errors++; $display("FAIL idle_lookup got type=%0d tp=%0d want 0 0", t, p);
        end
        test_load(1);
        step();
        for (int i = 0; i < 6; i++) begin
            cc = int'($urandom_range(0, C-1)); rr = int'($urandom_range(0, R-1));
            probe(cc, rr, t, p);
            checks++;
            if (t !== 3'(ref_t[rr][cc]) || p !== 8'(ref_p[rr][cc])) begin
                errors++; $display("FAIL reload_cell (%0d,%0d) got type=%0d tp=%0d want %0d %0d", cc, rr, t, p, ref_t[rr][cc], ref_p[rr][cc]);
            end
        end
    endtask

    initial begin
        int pick [4];
        pick = '{FREE, REGU, PORT, SPIK};
        for (int i = 0; i < 512; i++)
            rom[i] = {3'($urandom_range(0, 6)), 8'($urandom)};
        for (int i = 0; i < CELLS; i++)
            rom[2*CELLS + i] = {3'(pick[$urandom_range(0, 3)]), 8'($urandom)};
        rom[2*CELLS + 3*C + 3] = {3'(COIN), 8'h00};
        rom[2*CELLS + 4*C + 5] = {3'(COIN), 8'h00};
        rom[2*CELLS + 0*C + 7] = {3'(COIN), 8'h00};
        rom[2*CELLS + 6*C + 2] = {3'(COIN), 8'h00};
        rom[2*CELLS + 2*C + 0] = {3'(BRAK), 8'h00};
        rom[2*CELLS + 5*C + 4] = {3'(BRAK), 8'h00};
        rom[2*CELLS + 1*C + 9] = {3'(REGU), 8'h00};

        test_reset();
        test_load(2);
        test_lookup();
        test_out_of_grid();
        test_collect();
        test_gate();
        test_break();
        test_clear();
        test_reset_mid_load();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
